// File: rtl/serial_add.sv
// Bit-serial adder: two cascaded half adders plus a carry register add one bit per clock, LSB first.
// Optional signed-overflow flag and ovf port enabled by defining SERIAL_ADD_OVF_EN.
module serial_add #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {carry, sum} of a single half adder.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_r;
   logic [CNT_W-1:0] cnt_r;
   logic             c_r;
   logic             cout_r;
   logic             out_valid_r;
   logic             busy_r;
   logic             accept_s;
   logic             last_s;
   logic [1:0]       ha0_s;
   logic [1:0]       ha1_s;
   logic             bit_s;
   logic             c_nx_s;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_r;
`endif

   assign in_ready  = (state_r == ST_IDLE) & ~rst;
   assign accept_s  = in_valid & in_ready;
   assign last_s    = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = ovf_r;
`endif

   // Full-adder slice for the current bit built from two half adders.
   always_comb begin
      ha0_s  = half_add(a_sh_r[0], b_sh_r[0]);
      ha1_s  = half_add(ha0_s[0], c_r);
      bit_s  = ha1_s[0];
      c_nx_s = ha0_s[1] | ha1_s[1];
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nx_s = ST_RUN;
            else          state_nx_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_s) state_nx_s = ST_DONE;
            else        state_nx_s = ST_RUN;
         end
         ST_DONE: begin
            if (out_ready) state_nx_s = ST_IDLE;
            else           state_nx_s = ST_DONE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register with registered status flags that mirror the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         out_valid_r <= (state_nx_s == ST_DONE);
         busy_r      <= (state_nx_s != ST_IDLE);
      end
   end

   // Operand shifters, carry, bit counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r <= '0;
         b_sh_r <= '0;
         sum_r  <= '0;
         cnt_r  <= '0;
         c_r    <= 1'b0;
         cout_r <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_r  <= 1'b0;
`endif
      end else if (accept_s) begin
         a_sh_r <= a;
         b_sh_r <= b;
         c_r    <= cin;
         cnt_r  <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_r  <= 1'b0;
`endif
      end else if (state_r == ST_RUN) begin
         a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
         sum_r  <= {bit_s, sum_r[WIDTH-1:1]};
         c_r    <= c_nx_s;
         cnt_r  <= cnt_r + CNT_W'(1);
         // On the MSB edge c_r is the carry into the MSB and c_nx_s the carry out.
         if (last_s) begin
            cout_r <= c_nx_s;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r  <= c_r ^ c_nx_s;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: directed cases plus randomized operands against an arithmetic model.
// Define SERIAL_ADD_OVF_EN for both bench and RTL to exercise the overflow flag.
module tb_serial_add;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   serial_add #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; stall = cycles out_ready is held low once the result is valid,
   // pulse = drive a competing operand during the stall.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int stall, input bit pulse);
      logic [W:0] full;
      logic       exp_ovf;
      int         t;
      full    = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      exp_ovf = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
      out_ready = (stall == 0);
      t = 0;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      tick();                                   // E0
      in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_run", 32'(in_ready), 32'd0);
      repeat (W - 1) tick();
      chk("out_valid_early", 32'(out_valid), 32'd0);
      tick();                                   // E(W)
      chk("out_valid_latency", 32'(out_valid), 32'd1);
      chk("sum", 32'(sum), 32'(full[W-1:0]));
      chk("cout", 32'(cout), 32'(full[W]));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
      for (int s = 0; s < stall; s++) begin
         if (pulse) begin
            a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
         end
         tick();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", 32'(sum), 32'(full[W-1:0]));
         chk("hold_cout", 32'(cout), 32'(full[W]));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();                                   // output handshake
      chk("out_valid_drop", 32'(out_valid), 32'd0);
      chk("busy_drop", 32'(busy), 32'd0);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      repeat (2) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      // In-valid on a busy block is dropped; next accept at E(W+2) with out_ready high.
      do_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
      do_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
      do_op(8'h3C, 8'hC3, 1'b1, 0, 1'b0);

      // Backpressure with a competing operand, then that operand on its own.
      do_op(8'h44, 8'h55, 1'b1, 5, 1'b1);
      do_op(8'h11, 8'h22, 1'b0, 0, 1'b0);

      // Reset one cycle after bit 4 is processed.
      a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
      tick();                                   // E0
      in_valid = 1'b0;
      repeat (5) tick();                        // bit 4 at E5
      rst = 1'b1;
      tick();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (12) begin
         tick();
         if (out_valid) seen++;
      end
      chk("midrst_no_out_valid", 32'(seen), 32'd0);
      do_op(8'h03, 8'h04, 1'b0, 0, 1'b0);

      // Randomized operands and consumer stalls.
      for (int i = 0; i < 25; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_add.md
# serial_add

Bit-serial adder for WIDTH-bit unsigned/two's-complement operands. It is built around the half-add stage: two half adders plus a carry register form a full-adder slice that processes one bit per clock, LSB first. Operands arrive and results leave over valid/ready handshakes. It is the sequential consumer of the half-add sum/carry pair and the area-cheap alternative to a parallel adder in the basic-gates datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands; high only in IDLE and forced 0 while rst=1
- a  in  WIDTH  operand A; sampled only on input handshake
- b  in  WIDTH  operand B; sampled only on input handshake
- cin  in  1  carry-in; sampled only on input handshake
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a+b+cin modulo 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- busy  out  1  high in RUN or DONE
- ovf  out  1  signed overflow flag; present only with SERIAL_ADD_OVF_EN

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: out_valid=0, sum=0, cout=0, busy=0, ovf=0, bit counter=0, carry reg=0; in_ready=1 from the first cycle after rst deasserts.
- IDLE: in_ready=1. Input handshake (in_valid & in_ready at rising edge): load a, b into shift registers, carry reg<=cin, counter<=0, go RUN. in_valid without handshake has no effect.
- RUN: each edge computes s=a_sh[0]^b_sh[0]^c (two cascaded half adders); c<=carry of the two half adders ORed; a_sh, b_sh shift right; s enters sum register at MSB, sum shifts right; counter increments. After the edge with counter==WIDTH-1, go DONE with cout<=final carry.
- DONE: out_valid=1; sum, cout, ovf held stable until the output handshake. out_valid & out_ready at an edge -> IDLE, out_valid<=0. sum/cout keep last value after the handshake (don't-care to consumer).
- in_valid during RUN/DONE is ignored (in_ready=0); no queuing.
- Arithmetic: result exact modulo 2^WIDTH; {cout,sum} = a+b+cin (WIDTH+1 bits).
- Reset mid-operation (RUN or DONE): abort, all state to reset values, no out_valid pulse, result discarded.

## Timing
- Input handshake at edge E0; bit i processed at edge E(i+1); out_valid high after edge E(WIDTH), i.e. latency WIDTH cycles from accept to out_valid.
- With out_ready held high: out_valid high exactly one cycle; IDLE after E(WIDTH+1); next accept earliest at E(WIDTH+2). Throughput 1 op per WIDTH+2 cycles.
- in_ready and out_valid are pure state decodes (no combinational path from in_valid/out_ready).
- busy high from after E0 through the output handshake edge.

## Configuration
- SERIAL_ADD_OVF_EN defined: ovf port present; on the last RUN edge ovf<=carry-into-MSB XOR carry-out-of-MSB; valid with out_valid; cleared on reset and on input handshake.
- SERIAL_ADD_OVF_EN undefined: no ovf port, no overflow logic; all other behaviour identical.

## Test plan
- Reset, a=8'h00, b=8'h00, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h00, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1 (ovf checked only with macro defined).
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, ovf=0; with out_ready high, next operand accepted at E(10).
- Backpressure: out_ready low 5 cycles after out_valid, in_valid pulsed with a=8'h11 -> out_valid stays 1, sum/cout stable, in_ready=0, new operand not taken; out_ready high -> IDLE, then a=8'h11,b=8'h22 -> sum=8'h33.
- rst asserted one cycle after bit 4 of a=8'h0F,b=8'h01 -> no out_valid, in_ready=1 after reset; following op a=8'h03,b=8'h04,cin=0 -> sum=8'h07, cout=0.
